// File: rtl/shader_core_pkg.sv
// rtl/shader_core_pkg.sv - shared opcodes, ALU funct3 codes, FSM states and fixed encodings
package shader_core_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;
  localparam logic [2:0] F3_WORD = 3'b010;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
  localparam logic [31:0] ECALL_INSTR  = 32'h0000_0073;
  localparam logic [31:0] EBREAK_INSTR = 32'h0010_0073;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXECUTE,
    ST_LOAD_WAIT,
    ST_HALT
  } state_t;

endpackage

// File: rtl/shader_core_alu.sv
// rtl/shader_core_alu.sv - combinational RV32I ALU with compare flags for branches
module integer_alu
  import shader_core_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  funct3,
  input  logic        alt,
  output logic [31:0] result,
  output logic        eq,
  output logic        lt,
  output logic        ltu
);

  assign eq  = (a == b);
  assign lt  = ($signed(a) < $signed(b));
  assign ltu = (a < b);

  always_comb begin
    result = '0;
    case (funct3)
      F3_ADD:  result = alt ? (a - b) : (a + b);
      F3_SLL:  result = a << b[4:0];
      F3_SLT:  result = {31'b0, lt};
      F3_SLTU: result = {31'b0, ltu};
      F3_XOR:  result = a ^ b;
      F3_SR:   result = alt ? 32'($signed(a) >>> b[4:0]) : (a >> b[4:0]);
      F3_OR:   result = a | b;
      F3_AND:  result = a & b;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/shader_core.sv
// rtl/shader_core.sv - multicycle RV32I integer core (fetch/decode/execute/load-wait)
module shader_core
  import shader_core_pkg::*;
#(
  parameter int          ADDR_WIDTH = 16,
  parameter logic [31:0] RESET_PC   = 32'h0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  run,
  output logic [ADDR_WIDTH-1:0] inst_address,
  input  logic [31:0]           inst_data,
  output logic [ADDR_WIDTH-1:0] data_address,
  output logic                  data_write,
  output logic [31:0]           data_write_data,
  input  logic [31:0]           data_read_data,
  output logic [31:0]           pc,
  output logic                  halted,
  output logic                  illegal,
  output logic [31:0]           instret
);

  state_t      r_state, w_next_state;
  logic [31:0] r_pc, r_ir, r_instret;
  logic        r_illegal;
  logic [31:0] r_regs [1:31];

  logic [6:0]  w_opcode, w_funct7;
  logic [4:0]  w_rd, w_rs1, w_rs2;
  logic [2:0]  w_funct3;
  logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
  logic [31:0] w_rs1_val, w_rs2_val;
  logic [31:0] w_alu_b, w_alu_result;
  logic [2:0]  w_alu_f3;
  logic        w_alu_alt, w_eq, w_lt, w_ltu;
  logic [31:0] w_pc_plus4, w_branch_target, w_jal_target, w_jalr_target;
  logic        w_taken, w_branch_f3_ok, w_op_f7_ok, w_imm_f7_ok;

  logic [31:0] w_next_pc, w_rd_wdata;
  logic        w_rd_we, w_retire, w_fault, w_stop, w_store;

  assign w_opcode = r_ir[6:0];
  assign w_rd     = r_ir[11:7];
  assign w_funct3 = r_ir[14:12];
  assign w_rs1    = r_ir[19:15];
  assign w_rs2    = r_ir[24:20];
  assign w_funct7 = r_ir[31:25];

  assign w_imm_i = {{20{r_ir[31]}}, r_ir[31:20]};
  assign w_imm_s = {{20{r_ir[31]}}, r_ir[31:25], r_ir[11:7]};
  assign w_imm_b = {{19{r_ir[31]}}, r_ir[31], r_ir[7], r_ir[30:25], r_ir[11:8], 1'b0};
  assign w_imm_u = {r_ir[31:12], 12'b0};
  assign w_imm_j = {{11{r_ir[31]}}, r_ir[31], r_ir[19:12], r_ir[20], r_ir[30:21], 1'b0};

  assign w_rs1_val = (w_rs1 == 5'd0) ? 32'd0 : r_regs[w_rs1];
  assign w_rs2_val = (w_rs2 == 5'd0) ? 32'd0 : r_regs[w_rs2];

  // The ALU also forms rs1+imm for loads, stores and JALR, so one adder serves all.
  always_comb begin
    w_alu_b   = w_imm_i;
    w_alu_f3  = F3_ADD;
    w_alu_alt = 1'b0;
    if (w_opcode == OPC_OP || w_opcode == OPC_BRANCH) w_alu_b = w_rs2_val;
    else if (w_opcode == OPC_STORE)                   w_alu_b = w_imm_s;
    if (w_opcode == OPC_OP || w_opcode == OPC_OP_IMM) w_alu_f3 = w_funct3;
    if (w_opcode == OPC_OP || (w_opcode == OPC_OP_IMM && w_funct3 == F3_SR))
      w_alu_alt = r_ir[30];
  end

  integer_alu u_alu (
    .a      (w_rs1_val),
    .b      (w_alu_b),
    .funct3 (w_alu_f3),
    .alt    (w_alu_alt),
    .result (w_alu_result),
    .eq     (w_eq),
    .lt     (w_lt),
    .ltu    (w_ltu)
  );

  assign w_pc_plus4      = r_pc + 32'd4;
  assign w_branch_target = r_pc + w_imm_b;
  assign w_jal_target    = r_pc + w_imm_j;
  assign w_jalr_target   = {w_alu_result[31:1], 1'b0};

  assign w_op_f7_ok  = (w_funct7 == F7_BASE) ||
                       (w_funct7 == F7_ALT && (w_funct3 == F3_ADD || w_funct3 == F3_SR));
  assign w_imm_f7_ok = (w_funct3 == F3_SLL) ? (w_funct7 == F7_BASE) :
                       (w_funct3 == F3_SR)  ? (w_funct7 == F7_BASE || w_funct7 == F7_ALT) :
                       1'b1;

  always_comb begin
    w_taken        = 1'b0;
    w_branch_f3_ok = 1'b1;
    case (w_funct3)
      3'b000:  w_taken = w_eq;
      3'b001:  w_taken = !w_eq;
      3'b100:  w_taken = w_lt;
      3'b101:  w_taken = !w_lt;
      3'b110:  w_taken = w_ltu;
      3'b111:  w_taken = !w_ltu;
      default: w_branch_f3_ok = 1'b0;
    endcase
  end

  always_comb begin
    w_next_state = r_state;
    w_next_pc    = r_pc;
    w_rd_we      = 1'b0;
    w_rd_wdata   = w_alu_result;
    w_retire     = 1'b0;
    w_fault      = 1'b0;
    w_stop       = 1'b0;
    w_store      = 1'b0;
    case (r_state)
      ST_FETCH:  if (run) w_next_state = ST_DECODE;
      ST_DECODE: w_next_state = ST_EXECUTE;
      ST_EXECUTE: begin
        w_next_state = ST_FETCH;
        w_next_pc    = w_pc_plus4;
        w_retire     = 1'b1;
        case (w_opcode)
          OPC_OP: begin
            w_rd_we = w_op_f7_ok;
            w_fault = !w_op_f7_ok;
          end
          OPC_OP_IMM: begin
            w_rd_we = w_imm_f7_ok;
            w_fault = !w_imm_f7_ok;
          end
          OPC_LUI: begin
            w_rd_we    = 1'b1;
            w_rd_wdata = w_imm_u;
          end
          OPC_AUIPC: begin
            w_rd_we    = 1'b1;
            w_rd_wdata = r_pc + w_imm_u;
          end
          OPC_JAL: begin
            w_rd_we    = 1'b1;
            w_rd_wdata = w_pc_plus4;
            w_next_pc  = w_jal_target;
            w_fault    = (w_jal_target[1:0] != 2'b00);
          end
          OPC_JALR: begin
            w_rd_we    = 1'b1;
            w_rd_wdata = w_pc_plus4;
            w_next_pc  = w_jalr_target;
            w_fault    = (w_funct3 != 3'b000) || (w_jalr_target[1:0] != 2'b00);
          end
          OPC_BRANCH: begin
            if (w_taken) w_next_pc = w_branch_target;
            w_fault = !w_branch_f3_ok || (w_taken && w_branch_target[1:0] != 2'b00);
          end
          OPC_STORE: begin
            w_fault = (w_funct3 != F3_WORD) || (w_alu_result[1:0] != 2'b00);
            w_store = !w_fault;
          end
          OPC_LOAD: begin
            w_fault      = (w_funct3 != F3_WORD) || (w_alu_result[1:0] != 2'b00);
            w_next_state = ST_LOAD_WAIT;
            w_next_pc    = r_pc;
            w_retire     = 1'b0;
          end
          OPC_SYSTEM: begin
            w_stop  = 1'b1;
            w_fault = (r_ir != ECALL_INSTR) && (r_ir != EBREAK_INSTR);
          end
          default: w_fault = 1'b1;
        endcase
        // Halting leaves pc pointing at the offending instruction and commits nothing.
        if (w_fault || w_stop) begin
          w_next_state = ST_HALT;
          w_next_pc    = r_pc;
          w_rd_we      = 1'b0;
          w_retire     = 1'b0;
          w_store      = 1'b0;
        end
      end
      ST_LOAD_WAIT: begin
        w_next_state = ST_FETCH;
        w_next_pc    = w_pc_plus4;
        w_rd_we      = 1'b1;
        w_rd_wdata   = data_read_data;
        w_retire     = 1'b1;
      end
      ST_HALT:  w_next_state = ST_HALT;
      default:  w_next_state = ST_FETCH;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= ST_FETCH;
    else       r_state <= w_next_state;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pc      <= RESET_PC;
      r_ir      <= NOP_INSTR;
      r_instret <= 32'd0;
      r_illegal <= 1'b0;
    end else begin
      r_pc <= w_next_pc;
      if (r_state == ST_DECODE) r_ir <= inst_data;
      if (w_retire) r_instret <= r_instret + 32'd1;
      if (w_fault)  r_illegal <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (w_rd_we && w_rd != 5'd0) r_regs[w_rd] <= w_rd_wdata;
  end

  assign inst_address    = r_pc[ADDR_WIDTH-1:0];
  assign data_address    = {w_alu_result[ADDR_WIDTH-1:2], 2'b00};
  assign data_write      = w_store;
  assign data_write_data = w_rs2_val;
  assign pc              = r_pc;
  assign halted          = (r_state == ST_HALT);
  assign illegal         = r_illegal;
  assign instret         = r_instret;

endmodule

// File: tb/tb_shader_core.sv
// tb/tb_shader_core.sv - scoreboard bench for shader_core running small RV32I programs
module tb_shader_core;

  localparam int AW = 16;

  logic          clock = 1'b0;
  logic          reset;
  logic          run;
  logic [AW-1:0] inst_address;
  logic [31:0]   inst_data;
  logic [AW-1:0] data_address;
  logic          data_write;
  logic [31:0]   data_write_data;
  logic [31:0]   data_read_data;
  logic [31:0]   pc;
  logic          halted;
  logic          illegal;
  logic [31:0]   instret;

  shader_core #(.ADDR_WIDTH(AW), .RESET_PC(32'h0)) dut (
    .clock           (clock),
    .reset           (reset),
    .run             (run),
    .inst_address    (inst_address),
    .inst_data       (inst_data),
    .data_address    (data_address),
    .data_write      (data_write),
    .data_write_data (data_write_data),
    .data_read_data  (data_read_data),
    .pc              (pc),
    .halted          (halted),
    .illegal         (illegal),
    .instret         (instret)
  );

  always #5 clock = ~clock;

  logic [31:0] imem [0:255];
  logic [31:0] dmem [0:255];

  always @(posedge clock) begin
    inst_data      <= imem[inst_address[9:2]];
    data_read_data <= dmem[data_address[9:2]];
    if (data_write) dmem[data_address[9:2]] <= data_write_data;
  end

  int n_checks = 0;
  int n_errors = 0;
  int n_stores = 0;
  logic [63:0] sb_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clock) begin
    if (data_write) begin
      logic [63:0] e;
      n_stores++;
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check("store_addr", {16'b0, data_address}, e[63:32]);
        check("store_data", data_write_data, e[31:0]);
      end
    end
  end

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] enc_sw(input logic [11:0] imm, input logic [4:0] rs2,
                                         input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  localparam logic [6:0]  OP_IMM = 7'b0010011;
  localparam logic [6:0]  LOAD   = 7'b0000011;
  localparam logic [6:0]  JALR   = 7'b1100111;
  localparam logic [31:0] EBREAK = 32'h0010_0073;

  task automatic clear_mems();
    for (int i = 0; i < 256; i++) begin
      imem[i] = 32'h0;
      dmem[i] = 32'h0;
    end
    sb_q.delete();
    n_stores = 0;
  endtask

  task automatic hold_reset();
    reset = 1'b1;
    run   = 1'b0;
    @(negedge clock);
    @(negedge clock);
  endtask

  task automatic wait_halt(input int budget, output int cycles);
    cycles = 0;
    while (!halted && cycles < budget) begin
      @(negedge clock);
      cycles++;
    end
  endtask

  task automatic finish_prog(input string name, input int cycles, input int exp_cycles,
                             input logic exp_ill, input logic [31:0] exp_instret,
                             input logic [31:0] exp_pc, input int exp_stores);
    check({name, "_halted"}, {31'b0, halted}, 32'd1);
    check({name, "_cycles"}, cycles, exp_cycles);
    check({name, "_illegal"}, {31'b0, illegal}, {31'b0, exp_ill});
    check({name, "_instret"}, instret, exp_instret);
    check({name, "_pc"}, pc, exp_pc);
    check({name, "_stores"}, n_stores, exp_stores);
    check({name, "_sb_left"}, sb_q.size(), 32'd0);
  endtask

  initial begin
    int cyc;
    reset = 1'b1;
    run   = 1'b0;
    clear_mems();
    hold_reset();
    check("rst_pc", pc, 32'h0);
    check("rst_halted", {31'b0, halted}, 32'd0);
    check("rst_illegal", {31'b0, illegal}, 32'd0);
    check("rst_instret", instret, 32'd0);
    check("rst_data_write", {31'b0, data_write}, 32'd0);

    // P1: ADDI/ADDI/ADD/SW/EBREAK
    clear_mems();
    imem[0] = enc_i(12'd5, 5'd0, 3'b000, 5'd1, OP_IMM);
    imem[1] = enc_i(12'hFFD, 5'd0, 3'b000, 5'd2, OP_IMM);
    imem[2] = enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3);
    imem[3] = enc_sw(12'h040, 5'd3, 5'd0);
    imem[4] = EBREAK;
    sb_q.push_back({32'h40, 32'd5 + 32'hFFFF_FFFD});
    hold_reset();
    reset = 1'b0;
    run   = 1'b1;
    wait_halt(500, cyc);
    finish_prog("p1", cyc, 15, 1'b0, 32'd4, 32'h10, 1);

    // P2: SLT/SLTU/SRAI on 0x80000000 vs 1
    clear_mems();
    imem[0] = {20'h80000, 5'd1, 7'b0110111};
    imem[1] = enc_i(12'd1, 5'd0, 3'b000, 5'd2, OP_IMM);
    imem[2] = enc_r(7'h00, 5'd2, 5'd1, 3'b010, 5'd3);
    imem[3] = enc_sw(12'h040, 5'd3, 5'd0);
    imem[4] = enc_r(7'h00, 5'd2, 5'd1, 3'b011, 5'd3);
    imem[5] = enc_sw(12'h044, 5'd3, 5'd0);
    imem[6] = enc_i(12'h404, 5'd1, 3'b101, 5'd4, OP_IMM);
    imem[7] = enc_sw(12'h048, 5'd4, 5'd0);
    imem[8] = EBREAK;
    sb_q.push_back({32'h40, 32'd1});
    sb_q.push_back({32'h44, 32'd0});
    sb_q.push_back({32'h48, 32'hF800_0000});
    hold_reset();
    reset = 1'b0;
    run   = 1'b1;
    wait_halt(500, cyc);
    finish_prog("p2", cyc, 27, 1'b0, 32'd8, 32'h20, 3);

    // P3: BNE loop counting x1 to 3
    clear_mems();
    imem[0] = enc_i(12'd0, 5'd0, 3'b000, 5'd1, OP_IMM);
    imem[1] = enc_i(12'd3, 5'd0, 3'b000, 5'd2, OP_IMM);
    imem[2] = enc_i(12'd1, 5'd1, 3'b000, 5'd1, OP_IMM);
    imem[3] = enc_b(13'h1FFC, 5'd2, 5'd1, 3'b001);
    imem[4] = enc_sw(12'h040, 5'd1, 5'd0);
    imem[5] = EBREAK;
    sb_q.push_back({32'h40, 32'd3});
    hold_reset();
    reset = 1'b0;
    run   = 1'b1;
    wait_halt(500, cyc);
    finish_prog("p3", cyc, 30, 1'b0, 32'd9, 32'h14, 1);

    // P4: LW then ADD of the loaded value
    clear_mems();
    dmem[17] = 32'hDEAD_BEEF;
    imem[0] = enc_i(12'h044, 5'd0, 3'b010, 5'd5, LOAD);
    imem[1] = enc_r(7'h00, 5'd0, 5'd5, 3'b000, 5'd6);
    imem[2] = enc_sw(12'h040, 5'd6, 5'd0);
    imem[3] = EBREAK;
    sb_q.push_back({32'h40, 32'hDEAD_BEEF});
    hold_reset();
    reset = 1'b0;
    run   = 1'b1;
    wait_halt(500, cyc);
    finish_prog("p4", cyc, 13, 1'b0, 32'd3, 32'hC, 1);

    // P5: JALR to a misaligned target
    clear_mems();
    imem[0] = enc_i(12'h102, 5'd0, 3'b000, 5'd1, OP_IMM);
    imem[1] = enc_i(12'd0, 5'd1, 3'b000, 5'd0, JALR);
    hold_reset();
    reset = 1'b0;
    run   = 1'b1;
    wait_halt(500, cyc);
    finish_prog("p5", cyc, 6, 1'b1, 32'd1, 32'h4, 0);

    // P6: reset during the EXECUTE of an SW, then hold run low
    clear_mems();
    dmem[16] = 32'h5A5A_5A5A;
    imem[0] = enc_i(12'd7, 5'd0, 3'b000, 5'd1, OP_IMM);
    imem[1] = enc_sw(12'h040, 5'd1, 5'd0);
    imem[2] = EBREAK;
    hold_reset();
    reset = 1'b0;
    run   = 1'b1;
    repeat (5) @(posedge clock);
    #1;
    check("p6_sw_strobe", {31'b0, data_write}, 32'd1);
    check("p6_sw_addr", {16'b0, data_address}, 32'h40);
    reset = 1'b1;
    #1;
    check("p6_rst_data_write", {31'b0, data_write}, 32'd0);
    check("p6_rst_pc", pc, 32'h0);
    check("p6_rst_instret", instret, 32'd0);
    run = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    repeat (20) @(negedge clock);
    check("p6_idle_instret", instret, 32'd0);
    check("p6_idle_inst_addr", {16'b0, inst_address}, 32'h0);
    check("p6_idle_halted", {31'b0, halted}, 32'd0);
    check("p6_ram_unchanged", dmem[16], 32'h5A5A_5A5A);
    check("p6_stores", n_stores, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
